// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: arbiter states, grant side,
// default bus widths and the arbitration decision function.
package pmem_arbiter_pkg;

  localparam int PMEM_ADDR_WIDTH = 16;
  localparam int PMEM_LINE_WIDTH = 128;
  localparam int PMEM_CNT_WIDTH  = 16;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D,
    ARB_RELEASE
  } lc3b_arb_state;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_side_e;

  // On a tie the side that did not win last time is served, so D wins the first tie after reset.
  function automatic lc3b_arb_state pickNext(input logic iReq, input logic dReq,
                                             input arb_side_e lastGrant);
    if (iReq && dReq) begin
      return (lastGrant == GRANT_I) ? ARB_SERVE_D : ARB_SERVE_I;
    end else if (dReq) begin
      return ARB_SERVE_D;
    end else if (iReq) begin
      return ARB_SERVE_I;
    end
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the caches-plus-memory side.
interface pmem_arbiter_if
  import pmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = PMEM_ADDR_WIDTH,
  parameter int LINE_WIDTH = PMEM_LINE_WIDTH
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache fill path and the D-cache
// fill/writeback path, holding each grant until memory answers.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int CNT_WIDTH = PMEM_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  pmem_arbiter_if.slave        bus,
  output logic [CNT_WIDTH-1:0] i_grant_count,
  output logic [CNT_WIDTH-1:0] d_grant_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  lc3b_arb_state        r_state;
  arb_side_e            r_lastGrant;
  logic                 r_pmemRead;
  logic                 r_pmemWrite;
  logic [CNT_WIDTH-1:0] r_iCount;
  logic [CNT_WIDTH-1:0] r_dCount;

  lc3b_arb_state        w_next;

  always_comb begin
    w_next = pickNext(bus.i_pmem_read, bus.d_pmem_read | bus.d_pmem_write, r_lastGrant);
  end

  // RELEASE gives the finished cache one cycle to drop its level request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_lastGrant <= GRANT_I;
      r_pmemRead  <= 1'b0;
      r_pmemWrite <= 1'b0;
      r_iCount    <= '0;
      r_dCount    <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_state <= w_next;
          if (w_next == ARB_SERVE_I) begin
            r_lastGrant <= GRANT_I;
            r_pmemRead  <= 1'b1;
            r_pmemWrite <= 1'b0;
          end else if (w_next == ARB_SERVE_D) begin
            r_lastGrant <= GRANT_D;
            r_pmemRead  <= bus.d_pmem_read;
            r_pmemWrite <= bus.d_pmem_write;
          end
        end
        ARB_SERVE_I: begin
          if (bus.pmem_resp) begin
            r_state     <= ARB_RELEASE;
            r_pmemRead  <= 1'b0;
            r_pmemWrite <= 1'b0;
            if (r_iCount != CNT_MAX) r_iCount <= r_iCount + 1'b1;
          end
        end
        ARB_SERVE_D: begin
          if (bus.pmem_resp) begin
            r_state     <= ARB_RELEASE;
            r_pmemRead  <= 1'b0;
            r_pmemWrite <= 1'b0;
            if (r_dCount != CNT_MAX) r_dCount <= r_dCount + 1'b1;
          end
        end
        ARB_RELEASE: r_state <= ARB_IDLE;
        default:     r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = r_pmemRead;
  assign bus.pmem_write   = r_pmemWrite;
  assign bus.pmem_address = (r_lastGrant == GRANT_D) ? bus.d_pmem_address : bus.i_pmem_address;
  assign bus.pmem_wdata   = bus.d_pmem_wdata;

  // Responses only reach the side currently being served; stray pmem_resp is dropped.
  assign bus.i_pmem_resp  = bus.pmem_resp & (r_state == ARB_SERVE_I);
  assign bus.d_pmem_resp  = bus.pmem_resp & (r_state == ARB_SERVE_D);
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

  assign i_grant_count    = r_iCount;
  assign d_grant_count    = r_dCount;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: cache requesters and a memory model drive the bus,
// a monitor checks every response pulse against a hand-ordered expected queue.
module tb_pmem_arbiter;

  typedef struct {
    logic         side;
    logic [15:0]  addr;
    logic         isWrite;
    logic [127:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] iGrantCount, dGrantCount;
  logic [1:0]  satICount, satDCount;

  int   numChecks = 0;
  int   numErrors = 0;
  int   memLatency;
  logic spuriousResp;
  bit   iBusy, dBusy;
  txn_t iQ[$], dQ[$], expQ[$];

  always #5 clk = ~clk;

  pmem_arbiter_if bus ();
  pmem_arbiter_if busSat ();

  pmem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .i_grant_count (iGrantCount),
    .d_grant_count (dGrantCount)
  );

  // Narrow-counter copy sees identical traffic so saturation is reachable in a short run.
  pmem_arbiter #(.CNT_WIDTH(2)) dutSat (
    .clk           (clk),
    .reset         (reset),
    .bus           (busSat.slave),
    .i_grant_count (satICount),
    .d_grant_count (satDCount)
  );

  assign busSat.i_pmem_read    = bus.i_pmem_read;
  assign busSat.i_pmem_address = bus.i_pmem_address;
  assign busSat.d_pmem_read    = bus.d_pmem_read;
  assign busSat.d_pmem_write   = bus.d_pmem_write;
  assign busSat.d_pmem_address = bus.d_pmem_address;
  assign busSat.d_pmem_wdata   = bus.d_pmem_wdata;
  assign busSat.pmem_rdata     = bus.pmem_rdata;
  assign busSat.pmem_resp      = bus.pmem_resp;

  function automatic logic [127:0] lineOf(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    numChecks++;
    numErrors++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic side, input logic [15:0] addr,
                               input logic isWrite, input logic [127:0] wdata);
    txn_t t;
    t.side = side; t.addr = addr; t.isWrite = isWrite; t.data = wdata;
    if (side) dQ.push_back(t);
    else      iQ.push_back(t);
  endtask

  task automatic expectTxn(input logic side, input logic [15:0] addr,
                           input logic isWrite, input logic [127:0] wdata);
    txn_t t;
    t.side = side; t.addr = addr; t.isWrite = isWrite; t.data = wdata;
    expQ.push_back(t);
  endtask

  task automatic checkCounters(input string tag, input int expI, input int expD);
    checkOutput({tag, " i_grant_count"}, 128'(iGrantCount), 128'(expI));
    checkOutput({tag, " d_grant_count"}, 128'(dGrantCount), 128'(expD));
    checkOutput({tag, " sat i count"}, 128'(satICount), 128'((expI > 3) ? 3 : expI));
    checkOutput({tag, " sat d count"}, 128'(satDCount), 128'((expD > 3) ? 3 : expD));
  endtask

  task automatic waitIdle(input string tag);
    bit idle;
    idle = 0;
    for (int c = 0; c < 400 && !idle; c++) begin
      tick();
      idle = (iQ.size() == 0) && (dQ.size() == 0) && !iBusy && !dBusy && (expQ.size() == 0);
    end
    if (!idle) failNow({tag, " waitIdle timeout"});
    repeat (3) tick();
  endtask

  // Physical memory: answers a held read/write after memLatency cycles.
  initial begin : memModel
    int cnt;
    cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.pmem_resp || reset) begin
        bus.pmem_resp = 1'b0;
        cnt = 0;
      end else if (spuriousResp) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {4{32'hDEADBEEF}};
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt >= memLatency) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = lineOf(bus.pmem_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : iRequester
    txn_t cur;
    bit   done;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    iBusy = 0;
    forever begin
      @(negedge clk);
      if (iQ.size() > 0 && !reset) begin
        cur   = iQ.pop_front();
        iBusy = 1;
        bus.i_pmem_address = cur.addr;
        bus.i_pmem_read    = 1'b1;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
          tick();
          done = bus.i_pmem_resp || reset;
        end
        if (!done) failNow("i request timeout");
        bus.i_pmem_read = 1'b0;
        iBusy = 0;
      end
    end
  end

  initial begin : dRequester
    txn_t cur;
    bit   done;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    dBusy = 0;
    forever begin
      @(negedge clk);
      if (dQ.size() > 0 && !reset) begin
        cur   = dQ.pop_front();
        dBusy = 1;
        bus.d_pmem_address = cur.addr;
        bus.d_pmem_wdata   = cur.data;
        bus.d_pmem_read    = !cur.isWrite;
        bus.d_pmem_write   = cur.isWrite;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
          tick();
          done = bus.d_pmem_resp || reset;
        end
        if (!done) failNow("d request timeout");
        bus.d_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
        dBusy = 0;
      end
    end
  end

  // Every response pulse must match the next expected transaction in grant order.
  initial begin : monitor
    txn_t e;
    forever begin
      tick();
      if (bus.i_pmem_resp && bus.d_pmem_resp) begin
        failNow("both resp pulses together");
      end else if (bus.i_pmem_resp || bus.d_pmem_resp) begin
        if (expQ.size() == 0) begin
          failNow("unexpected resp pulse");
        end else begin
          e = expQ.pop_front();
          checkOutput("resp side", 128'(bus.d_pmem_resp), 128'(e.side));
          checkOutput("pmem_address", 128'(bus.pmem_address), 128'(e.addr));
          checkOutput("pmem_write", 128'(bus.pmem_write), 128'(e.isWrite));
          checkOutput("pmem_read", 128'(bus.pmem_read), 128'(!e.isWrite));
          if (e.isWrite) checkOutput("pmem_wdata", bus.pmem_wdata, e.data);
          else if (e.side) checkOutput("d_pmem_rdata", bus.d_pmem_rdata, lineOf(e.addr));
          else checkOutput("i_pmem_rdata", bus.i_pmem_rdata, lineOf(e.addr));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainFlow
    bit seen;
    reset        = 1'b1;
    spuriousResp = 1'b0;
    memLatency   = 4;
    repeat (2) tick();
    checkOutput("reset pmem_read", 128'(bus.pmem_read), 128'(0));
    checkOutput("reset pmem_write", 128'(bus.pmem_write), 128'(0));
    checkOutput("reset i_pmem_resp", 128'(bus.i_pmem_resp), 128'(0));
    checkOutput("reset d_pmem_resp", 128'(bus.d_pmem_resp), 128'(0));
    checkCounters("reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) tick();

    $display("[TB] I-only fill with one-cycle grant latency");
    expectTxn(1'b0, 16'h1230, 1'b0, '0);
    applyStimulus(1'b0, 16'h1230, 1'b0, '0);
    tick();
    checkOutput("t1 i_pmem_read raised", 128'(bus.i_pmem_read), 128'(1));
    checkOutput("t1 pmem_read first cycle", 128'(bus.pmem_read), 128'(0));
    tick();
    checkOutput("t1 pmem_read granted", 128'(bus.pmem_read), 128'(1));
    checkOutput("t1 pmem_address", 128'(bus.pmem_address), 128'(16'h1230));
    waitIdle("t1");
    checkCounters("t1", 1, 0);

    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    checkCounters("reset2", 0, 0);

    $display("[TB] Tie after reset: D writeback first, then I");
    expectTxn(1'b1, 16'h3000, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    expectTxn(1'b0, 16'h2000, 1'b0, '0);
    applyStimulus(1'b0, 16'h2000, 1'b0, '0);
    applyStimulus(1'b1, 16'h3000, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    waitIdle("t2");
    checkCounters("t2", 1, 1);

    $display("[TB] Sustained contention alternates D,I,D,I,D,I");
    expectTxn(1'b1, 16'h4000, 1'b0, '0);
    expectTxn(1'b0, 16'h5000, 1'b0, '0);
    expectTxn(1'b1, 16'h4010, 1'b1, {4{32'hA5A5_0F0F}});
    expectTxn(1'b0, 16'h5010, 1'b0, '0);
    expectTxn(1'b1, 16'h4020, 1'b0, '0);
    expectTxn(1'b0, 16'h5020, 1'b0, '0);
    applyStimulus(1'b1, 16'h4000, 1'b0, '0);
    applyStimulus(1'b1, 16'h4010, 1'b1, {4{32'hA5A5_0F0F}});
    applyStimulus(1'b1, 16'h4020, 1'b0, '0);
    applyStimulus(1'b0, 16'h5000, 1'b0, '0);
    applyStimulus(1'b0, 16'h5010, 1'b0, '0);
    applyStimulus(1'b0, 16'h5020, 1'b0, '0);
    waitIdle("t3");
    checkCounters("t3", 4, 4);

    $display("[TB] Stray pmem_resp in IDLE");
    spuriousResp = 1'b1;
    tick();
    spuriousResp = 1'b0;
    checkOutput("t4 stray resp present", 128'(bus.pmem_resp), 128'(1));
    checkOutput("t4 i_pmem_resp", 128'(bus.i_pmem_resp), 128'(0));
    checkOutput("t4 d_pmem_resp", 128'(bus.d_pmem_resp), 128'(0));
    repeat (2) tick();
    checkCounters("t4", 4, 4);

    $display("[TB] Reset two cycles into SERVE_D");
    memLatency = 20;
    applyStimulus(1'b1, 16'h6000, 1'b0, '0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = bus.pmem_read;
    end
    if (!seen) failNow("t5 grant never seen");
    @(negedge clk);
    reset = 1'b1;
    #2;
    checkOutput("t5 pmem_read before reset edge", 128'(bus.pmem_read), 128'(1));
    tick();
    checkOutput("t5 pmem_read after reset", 128'(bus.pmem_read), 128'(0));
    checkOutput("t5 pmem_write after reset", 128'(bus.pmem_write), 128'(0));
    checkCounters("t5 reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    memLatency = 4;
    #2;
    spuriousResp = 1'b1;
    tick();
    spuriousResp = 1'b0;
    checkOutput("t5 late d_pmem_resp", 128'(bus.d_pmem_resp), 128'(0));
    checkOutput("t5 late i_pmem_resp", 128'(bus.i_pmem_resp), 128'(0));
    repeat (2) tick();
    checkCounters("t5 late", 0, 0);

    $display("[TB] Counter saturation on the narrow copy");
    for (int k = 0; k < 2; k++) begin
      expectTxn(1'b1, 16'(16'h7000 + 16'(k * 16)), 1'b0, '0);
      applyStimulus(1'b1, 16'(16'h7000 + 16'(k * 16)), 1'b0, '0);
    end
    waitIdle("t6a");
    checkCounters("t6a", 0, 2);
    for (int k = 2; k < 5; k++) begin
      expectTxn(1'b1, 16'(16'h7000 + 16'(k * 16)), 1'b0, '0);
      applyStimulus(1'b1, 16'(16'h7000 + 16'(k * 16)), 1'b0, '0);
    end
    waitIdle("t6b");
    checkCounters("t6b", 0, 5);

    checkOutput("expected queue drained", 128'(expQ.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
